param_alu_ticker: RTL

- Parametrised registered arithmetic unit with a built-in tick divider, for use inside the tt_um top-level wrapper.
- Adds or subtracts two WIDTH-bit operands, or accumulates them, with carry reporting. Also offers a saturating-add mode.
- Records a sticky overflow flag.
- Generates a periodic enable strobe and a square-wave data signal in place of a derived clock; no logic runs on a divided clock.

---
 rtl/param_alu_ticker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/param_alu_ticker.sv
// param_alu_ticker: registered add/sub/accumulate/saturating-add unit with a
// sticky overflow flag, plus a tick divider that produces an enable strobe and
// a square-wave data signal. Everything runs on clk; nothing uses a divided clock.
module param_alu_ticker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             out_valid,
   output logic             ovf_sticky,
   output logic             tick,
   output logic             sq_out
);

   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_SUB    = 2'b01,
      OP_ACC    = 2'b10,
      OP_SATADD = 2'b11
   } op_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   op_t              op;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH:0]   sum_ab;
   logic [WIDTH:0]   diff_ab;
   logic [WIDTH:0]   acc_sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             accept;
   logic [CNT_W-1:0] cnt;

   assign accept = ena & in_valid;

   // Combinational datapath: WIDTH+1-bit sums, operation select by mode.
   always_comb begin
      op       = op_t'(mode);
      // clr in the same cycle as ACC restarts the accumulation from zero
      acc_base = clr ? '0 : acc;
      sum_ab   = {1'b0, a} + {1'b0, b};
      diff_ab  = {1'b0, a} - {1'b0, b};
      acc_sum  = {1'b0, acc_base} + {1'b0, a};
      alu_res  = '0;
      alu_c    = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_ab[WIDTH-1:0];
            alu_c   = sum_ab[WIDTH];
         end
         OP_SUB: begin
            alu_res = diff_ab[WIDTH-1:0];
            alu_c   = diff_ab[WIDTH];
         end
         OP_ACC: begin
            alu_res = acc_sum[WIDTH-1:0];
            alu_c   = acc_sum[WIDTH];
         end
         OP_SATADD: begin
            alu_res = sum_ab[WIDTH] ? '1 : sum_ab[WIDTH-1:0];
            alu_c   = sum_ab[WIDTH];
         end
         default: begin
            alu_res = '0;
            alu_c   = 1'b0;
         end
      endcase
   end

   // Result, carry, valid pulse, accumulator and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result     <= '0;
         carry      <= 1'b0;
         out_valid  <= 1'b0;
         ovf_sticky <= 1'b0;
         acc        <= '0;
      end else if (ena) begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= alu_res;
            carry  <= alu_c;
         end
         if (in_valid && op == OP_ACC)
            acc <= acc_sum[WIDTH-1:0];
         else if (clr)
            acc <= '0;
         // a new overflow in the clearing cycle takes priority over clr
         if (accept && alu_c)
            ovf_sticky <= 1'b1;
         else if (clr)
            ovf_sticky <= 1'b0;
      end else begin
         out_valid <= 1'b0;
      end
   end

   // Tick divider: wraps every DIV enabled cycles, strobes tick and toggles sq_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         tick   <= 1'b0;
         sq_out <= 1'b0;
      end else if (ena) begin
         if (cnt == CNT_LAST) begin
            cnt    <= '0;
            tick   <= 1'b1;
            sq_out <= ~sq_out;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule
